// File: rtl/led_frame_buffer_pkg.sv
// Shared types and constants for the LED frame buffer.
package led_frame_buffer_pkg;

    // Default LED word width, packed as {G[3:0], R[3:0], B[3:0]}
    localparam int unsigned LED_COLOR_W = 12;

    // GRB field positions inside a colour word
    localparam int unsigned G_MSB = 11;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 4;
    localparam int unsigned B_MSB = 3;
    localparam int unsigned B_LSB = 0;

    // Frame transmit sequencer states
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } fb_state_e;

    // Common colours
    localparam logic [LED_COLOR_W-1:0] BLACK = 12'h000;
    localparam logic [LED_COLOR_W-1:0] GREEN = 12'hF00;
    localparam logic [LED_COLOR_W-1:0] RED   = 12'h0F0;
    localparam logic [LED_COLOR_W-1:0] BLUE  = 12'h00F;

endpackage

// File: rtl/led_bank_ram.sv
// One bank of per-LED colour words: synchronous write, combinational read.
module led_bank_ram #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned COLOR_W  = 12,
    parameter int unsigned AW       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [COLOR_W-1:0] rdata
);

    // Sized to the full address space so any index is legal; rows at or
    // above NUM_LEDS are never written and stay constant black.
    logic [COLOR_W-1:0] mem [2**AW];

    // Clear to black on reset, otherwise store in-range writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < NUM_LEDS)) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read; out-of-range slots read as black
    always_comb begin
        rdata = '0;
        if (32'(raddr) < NUM_LEDS) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered LED colour store feeding the WS2812B send path.
module led_frame_buffer
    import led_frame_buffer_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned COLOR_W  = LED_COLOR_W,
    parameter int unsigned AW       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               commit,
    input  logic [AW-1:0]      num_leds,
    input  logic               go,
    output logic               ready,
    output logic [COLOR_W-1:0] pix_data,
    output logic               pix_valid,
    output logic               pix_last,
    input  logic               pix_ready,
    output logic               frame_done,
    output logic               commit_pend
);

    localparam logic [AW-1:0] MAX_IDX = AW'(NUM_LEDS - 1);

    fb_state_e          state_q, state_d;
    logic               front_q, front_d;        // 1: bank1 is the front bank
    logic               commit_pend_q, commit_pend_d;
    logic [AW-1:0]      index_q, index_d;
    logic [AW-1:0]      last_q, last_d;
    logic [COLOR_W-1:0] rdata0, rdata1;

    // Writes always land in whichever bank is currently the back bank
    led_bank_ram #(
        .NUM_LEDS (NUM_LEDS),
        .COLOR_W  (COLOR_W),
        .AW       (AW)
    ) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en & front_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (index_q),
        .rdata (rdata0)
    );

    led_bank_ram #(
        .NUM_LEDS (NUM_LEDS),
        .COLOR_W  (COLOR_W),
        .AW       (AW)
    ) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en & ~front_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (index_q),
        .rdata (rdata1)
    );

    // State, bank select, pending swap and frame index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            front_q       <= 1'b0;
            commit_pend_q <= 1'b0;
            index_q       <= '0;
            last_q        <= '0;
        end else begin
            state_q       <= state_d;
            front_q       <= front_d;
            commit_pend_q <= commit_pend_d;
            index_q       <= index_d;
            last_q        <= last_d;
        end
    end

    // Next-state logic, swap bookkeeping and handshake outputs
    always_comb begin
        state_d       = state_q;
        front_d       = front_q;
        commit_pend_d = commit_pend_q;
        index_d       = index_q;
        last_d        = last_q;
        ready         = 1'b0;
        pix_valid     = 1'b0;
        pix_last      = 1'b0;
        frame_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (go) begin
                    index_d = '0;
                    last_d  = (32'(num_leds) > NUM_LEDS - 1) ? MAX_IDX : num_leds;
                    state_d = SEND;
                    // Swap only between frames so a frame is never torn
                    if (commit_pend_q) begin
                        front_d       = ~front_q;
                        commit_pend_d = 1'b0;
                    end
                end
            end
            SEND: begin
                pix_valid = 1'b1;
                pix_last  = (index_q == last_q);
                if (pix_ready) begin
                    if (pix_last) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A commit coinciding with a swap arms a fresh pending swap
        if (commit) begin
            commit_pend_d = 1'b1;
        end
    end

    // Front-bank word, forced black outside SEND
    always_comb begin
        pix_data = '0;
        if (state_q == SEND) begin
            pix_data = front_q ? rdata1 : rdata0;
        end
    end

    assign commit_pend = commit_pend_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer against a frame-queue model.
module tb_led_frame_buffer;

    localparam int NL = 4;
    localparam int AW = 3;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic [AW-1:0] num_leds = '0;
    logic          go = 1'b0;
    logic          pix_ready = 1'b0;
    logic          ready;
    logic [CW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic          frame_done;
    logic          commit_pend;

    led_frame_buffer #(
        .NUM_LEDS (NL),
        .COLOR_W  (CW),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .num_leds    (num_leds),
        .go          (go),
        .ready       (ready),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .frame_done  (frame_done),
        .commit_pend (commit_pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: two banks, a front pointer, a pending flag, and the
    // queue of words still to be handed over for the frame in flight.
    logic [CW-1:0] mem [2][NL];
    int            front;
    bit            pend;
    logic [CW-1:0] mq[$];
    bit            m_done;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NL; i++) mem[b][i] = '0;
        front  = 0;
        pend   = 0;
        m_done = 0;
        mq.delete();
    endtask

    task automatic model_update();
        bit go_acc;
        int n;
        if (!reset) begin
            model_reset();
            return;
        end
        go_acc = (mq.size() == 0) && !m_done && go;
        m_done = (mq.size() == 1) && pix_ready;
        if (wr_en && int'(wr_addr) < NL) mem[1-front][int'(wr_addr)] = wr_data;
        if (mq.size() > 0 && pix_ready) void'(mq.pop_front());
        if (go_acc) begin
            if (pend) begin
                front = 1 - front;
                pend  = 0;
            end
            n = (int'(num_leds) > NL - 1) ? NL - 1 : int'(num_leds);
            for (int i = 0; i <= n; i++) mq.push_back(mem[front][i]);
        end
        if (commit) pend = 1;
    endtask

    // Observed accepted words and frame_done pulses
    logic [CW-1:0] got[$];
    int            done_cnt = 0;

    // Compare DUT outputs against the model every falling edge
    always @(negedge clk) begin
        logic [CW-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        check("ready", ready, (mq.size() == 0) && !m_done);
        check("pix_valid", pix_valid, mq.size() > 0);
        check("pix_last", pix_last, mq.size() == 1);
        check("pix_data", pix_data, exp_data);
        check("frame_done", frame_done, m_done);
        check("commit_pend", commit_pend, pend);
        if (pix_valid && pix_ready) got.push_back(pix_data);
        if (frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
        go     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle", ready, 1'b1);
    endtask

    task automatic write(input int a, input logic [CW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
    endtask

    task automatic run_frame(input int nl);
        got.delete();
        num_leds = AW'(nl);
        go = 1'b1;
        tick();
        wait_idle();
    endtask

    task automatic check_got(input string name, input int n, input logic [CW-1:0] w0,
                             input logic [CW-1:0] w1, input logic [CW-1:0] w2);
        check({name, "_len"}, got.size(), n);
        if (got.size() >= 3) begin
            check({name, "_w0"}, got[0], w0);
            check({name, "_w1"}, got[1], w1);
            check({name, "_w2"}, got[2], w2);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [4:0] pat;
        int       d0;
        model_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_valid", pix_valid, 1'b0);
        check("rst_data", pix_data, 12'h000);
        check("rst_pend", commit_pend, 1'b0);
        tick();
        reset = 1'b1;
        pix_ready = 1'b1;

        // Black frame straight out of reset
        d0 = done_cnt;
        run_frame(2);
        check_got("blank", 3, 12'h000, 12'h000, 12'h000);
        check("blank_done", done_cnt - d0, 1);

        // Writes stay hidden until commit + go
        write(0, 12'hF00);
        write(1, 12'h0F0);
        write(2, 12'h00F);
        run_frame(2);
        check_got("nocommit", 3, 12'h000, 12'h000, 12'h000);
        commit = 1'b1;
        tick();
        check("pend_set", commit_pend, 1'b1);
        got.delete();
        num_leds = 3'd2;
        go = 1'b1;
        tick();
        check("pend_clr", commit_pend, 1'b0);
        wait_idle();
        check_got("swapped", 3, 12'hF00, 12'h0F0, 12'h00F);

        // Downstream stalls hold the current word
        pat = 5'b11001;
        got.delete();
        num_leds = 3'd2;
        go = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            pix_ready = pat[i];
            tick();
        end
        pix_ready = 1'b1;
        wait_idle();
        check_got("stall", 3, 12'hF00, 12'h0F0, 12'h00F);

        // Out-of-range writes, go while busy, num_leds clamp
        write(5, 12'hABC);
        write(6, 12'h123);
        d0 = done_cnt;
        got.delete();
        num_leds = 3'd7;
        go = 1'b1;
        tick();
        go = 1'b1;
        tick();
        go = 1'b1;
        tick();
        wait_idle();
        tick();
        tick();
        tick();
        check("clamp_len", got.size(), 4);
        check("busy_go_done", done_cnt - d0, 1);
        check("busy_go_ready", ready, 1'b1);

        // Commit + write in the go-accept cycle of a pending swap
        commit = 1'b1;
        tick();
        got.delete();
        num_leds = 3'd3;
        go       = 1'b1;
        commit   = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 12'h0FF;
        tick();
        check("repend", commit_pend, 1'b1);
        wait_idle();
        check_got("samecycle", 4, 12'h000, 12'h0FF, 12'h000);

        // Reset on the second beat of a frame
        got.delete();
        num_leds = 3'd3;
        go = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", pix_valid, 1'b0);
        check("midrst_ready", ready, 1'b1);
        check("midrst_pend", commit_pend, 1'b0);
        check("midrst_data", pix_data, 12'h000);
        tick();
        reset = 1'b1;
        run_frame(3);
        check_got("postrst_a", 4, 12'h000, 12'h000, 12'h000);
        commit = 1'b1;
        tick();
        run_frame(3);
        check_got("postrst_b", 4, 12'h000, 12'h000, 12'h000);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, 7));
            wr_data   = CW'($urandom);
            commit    = ($urandom_range(0, 9) == 0);
            go        = ($urandom_range(0, 2) == 0);
            num_leds  = AW'($urandom_range(0, 7));
            pix_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            model_update();
            #1;
        end
        wr_en = 1'b0;
        commit = 1'b0;
        go = 1'b0;
        pix_ready = 1'b1;
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_frame_buffer.md
Name: led_frame_buffer

Overview:
- Double-buffered per-LED colour store that sits directly upstream of the WS2812B send path.
- Game/pattern logic writes 12-bit GRB words into a back bank.
- A commit request swaps banks at the next frame start.
- On go, the block streams the front bank one LED word per handshake to the GRB shift/encode stage, so a frame is never torn mid-transmission.

Parameters:
- NUM_LEDS, 8, physical LED slots stored per bank (2..256)
- COLOR_W, 12, bits per LED word, ordered {G[3:0],R[3:0],B[3:0]}
- AW, 3, address width; NUM_LEDS <= 2**AW

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe into back bank
- wr_addr  input  AW  LED index for write
- wr_data  input  COLOR_W  GRB word for write
- commit  input  1  request bank swap at next frame start
- num_leds  input  AW  active LED count minus 1 (0 -> 1 LED)
- go  input  1  start transmitting one frame
- ready  output  1  high in IDLE; go accepted only when high
- pix_data  output  COLOR_W  current LED word (front bank)
- pix_valid  output  1  pix_data valid
- pix_last  output  1  current word is final LED of frame
- pix_ready  input  1  downstream has accepted pix_data this cycle
- frame_done  output  1  one-cycle pulse after last word accepted
- commit_pend  output  1  swap requested, not yet applied

Behaviour:
- Reset (reset=0, async): both banks cleared to 0 (black), front=bank0, state IDLE, commit_pend=0, index=0. Outputs: ready=1, pix_valid=0, pix_last=0, frame_done=0, pix_data=0.
- Storage is flip-flop arrays with combinational read: pix_data = front[index] in SEND, 0 otherwise.
- Writes:
  - wr_en=1 with wr_addr<NUM_LEDS writes the current back bank on the clock edge.
  - wr_addr>=NUM_LEDS is ignored.
  - Writes are allowed in every state.
- Commit: commit=1 sets commit_pend. Repeated commits while pending have no further effect.
- FSM states:
  - IDLE: ready=1. If go=1, the swap rule below applies, index<=0, next state SEND.
  - SEND: pix_valid=1. pix_last=1 when index==min(num_leds, NUM_LEDS-1). On pix_valid&pix_ready: if not last, index<=index+1; if last, next state DONE. Without pix_ready, index and pix_data hold stable.
  - DONE: frame_done=1 for exactly this one cycle, ready=0, next state IDLE.
- Swap rule:
  - On the go-accept edge with commit_pend=1: front<=back, back<=old front, commit_pend<=0.
  - commit=1 in that same cycle re-sets commit_pend (new pending swap).
  - wr_en in the swap cycle writes the pre-swap back bank, so the data appears in the frame being sent.
  - After a swap, the new back bank holds the frame before last; producers rewrite the full frame before the next commit.
- num_leds is sampled at go-accept and held for the frame. Values > NUM_LEDS-1 are clamped to NUM_LEDS-1.
- go in SEND or DONE is ignored (no queuing).
- Throughput: one word per cycle when pix_ready is held high. A frame of N LEDs occupies N SEND cycles + 1 DONE cycle minimum.
- reset asserted mid-frame aborts immediately. Banks are cleared, and the downstream stage is also reset by the same reset net.

Decomposition:
- Shared package holds:
  - COLOR_W
  - GRB field offsets (G=11:8, R=7:4, B=3:0)
  - FSM state encoding {IDLE, SEND, DONE}
  - colour constants BLACK=12'h000, GREEN=12'hF00, RED=12'h0F0, BLUE=12'h00F
- One natural sub-module: led_bank_ram, a single NUM_LEDS x COLOR_W register bank with sync write and async read, instantiated twice.
- Swap bookkeeping and FSM live in the top.

Test Plan:
- Reset, then go with num_leds=2 and pix_ready=1 -> pix_valid for 3 cycles with pix_data 000,000,000, pix_last on third, frame_done pulse next cycle, ready returns high.
- Write addr0..2 = F00,0F0,00F, no commit, go -> frame still all 000. Then commit, go -> F00,0F0,00F, commit_pend clears on go-accept.
- pix_ready toggled 1,0,0,1,1 during a 3-LED frame -> index and pix_data hold during stalls, exactly 3 accepted words, pix_last only on the word at index 2.
- go asserted during SEND -> ignored, only one frame_done. num_leds=7 with NUM_LEDS=4 -> 4 words, clamped last index 3. wr_addr=5 write ignored.
- commit and wr_en (addr1=0FF) in the same cycle as go with pending swap -> 0FF is sent at index1 in that frame, and commit_pend=1 afterward.
- reset pulsed low at the second beat of a frame -> outputs immediately at reset values, banks read 000 on the next frame.
